// File: rtl/load_store_unit_if.sv
// Bundle of the EX/MEM request, data-memory port and load-response signals seen by the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic        resp_valid;
  logic        misaligned_err;
  logic        timeout_err;
  logic        stall;

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output load_word, load_byte, resp_valid, misaligned_err, timeout_err, stall
  );

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  load_word, load_byte, resp_valid, misaligned_err, timeout_err, stall
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: one word/byte access at a time to a variable-latency memory,
// stalling the pipeline until ack, with misalignment and timeout error reporting.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.slave   bus
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     load_word_q, load_word_d;
  logic [7:0]      load_byte_q, load_byte_d;
  logic            mis_err_q, mis_err_d;
  logic            to_err_q, to_err_d;
  logic            misaligned;

  assign misaligned = ~bus.req_byte & (bus.req_addr[1:0] != 2'b00);
  assign cnt_inc    = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lane_d      = lane_q;
    load_word_d = load_word_q;
    load_byte_d = load_byte_q;
    mis_err_d   = mis_err_q;
    to_err_d    = to_err_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (misaligned) begin
            mis_err_d = 1'b1;
            state_d   = StResp;
          end else begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_write;
            mem_be_d    = bus.req_byte ? (4'b0001 << bus.req_addr[1:0]) : 4'b1111;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wdata_d = bus.req_byte ? {4{bus.req_wdata[7:0]}} : bus.req_wdata;
            lane_d      = bus.req_addr[1:0];
            cnt_d       = '0;
            state_d     = StAccess;
          end
        end
      end
      StAccess: begin
        if (bus.mem_ack) begin
          // An ack on the final allowed cycle still counts as success.
          mem_en_d = 1'b0;
          state_d  = StResp;
          if (!mem_we_q) begin
            load_word_d = bus.mem_rdata;
            load_byte_d = bus.mem_rdata[{lane_q, 3'b000} +: 8];
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(MAX_WAIT)) begin
            to_err_d = 1'b1;
            mem_en_d = 1'b0;
            state_d  = StResp;
          end
        end
      end
      StResp: begin
        mis_err_d = 1'b0;
        to_err_d  = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lane_q      <= 2'b00;
      load_word_q <= '0;
      load_byte_q <= '0;
      mis_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lane_q      <= lane_d;
      load_word_q <= load_word_d;
      load_byte_q <= load_byte_d;
      mis_err_q   <= mis_err_d;
      to_err_q    <= to_err_d;
    end
  end

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.resp_valid     = (state_q == StResp);
  assign bus.stall          = (state_q == StAccess) |
                              ((state_q == StIdle) & bus.req_valid & ~misaligned);
  assign bus.mem_en         = mem_en_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_be         = mem_be_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.load_word      = load_word_q;
  assign bus.load_byte      = load_byte_q;
  assign bus.misaligned_err = mis_err_q;
  assign bus.timeout_err    = to_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, hand sequences, randomized traffic.
module tb_load_store_unit;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        write;
    logic        byte_acc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;   // mem_en cycle carrying the ack; 0 or > MW means never
    logic        late_ack;  // also pulse mem_ack during the response cycle
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_to;
    logic [31:0] exp_lw;
    logic [7:0]  exp_lb;
  } txn_t;

  int    vectors = 0;
  int    miscompares = 0;
  string ctx = "";

  // Architectural model of the load result registers.
  logic [31:0] ml_word = '0;
  logic [7:0]  ml_byte = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %h expected %h at %0t", ctx, nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(logic w, logic b, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, int ack, logic late, logic [3:0] be,
                              logic [31:0] ma, logic [31:0] ewd, logic mis, logic to,
                              logic [31:0] lw, logic [7:0] lb);
    txn_t t;
    t.write = w; t.byte_acc = b; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.ack_cyc = ack; t.late_ack = late; t.exp_be = be; t.exp_maddr = ma;
    t.exp_wdata = ewd; t.exp_mis = mis; t.exp_to = to; t.exp_lw = lw; t.exp_lb = lb;
    return t;
  endfunction

  function automatic txn_t predict(txn_t t);
    txn_t r = t;
    int   lane = int'(t.addr[1:0]);
    r.exp_mis   = !t.byte_acc && (lane != 0);
    r.exp_to    = !r.exp_mis && !(t.ack_cyc >= 1 && t.ack_cyc <= MW);
    r.exp_be    = t.byte_acc ? 4'(1 << lane) : 4'hF;
    r.exp_maddr = t.addr & 32'hFFFF_FFFC;
    r.exp_wdata = t.byte_acc ? (t.wdata & 32'hFF) * 32'h0101_0101 : t.wdata;
    r.exp_lw    = ml_word;
    r.exp_lb    = ml_byte;
    if (!r.exp_mis && !r.exp_to && !t.write) begin
      r.exp_lw = t.rdata;
      r.exp_lb = 8'((t.rdata >> (8 * lane)) & 32'hFF);
    end
    return r;
  endfunction

  task automatic check_reset_state();
    chk("rst.req_ready", bus.req_ready, 1);
    chk("rst.mem_en", bus.mem_en, 0);
    chk("rst.mem_we", bus.mem_we, 0);
    chk("rst.mem_be", bus.mem_be, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    chk("rst.mem_wdata", bus.mem_wdata, 0);
    chk("rst.load_word", bus.load_word, 0);
    chk("rst.load_byte", bus.load_byte, 0);
    chk("rst.resp_valid", bus.resp_valid, 0);
    chk("rst.misaligned_err", bus.misaligned_err, 0);
    chk("rst.timeout_err", bus.timeout_err, 0);
    chk("rst.stall", bus.stall, 0);
  endtask

  // Entered just after a rising edge with the DUT idle; leaves just after the edge out of RESP.
  task automatic run_txn(input txn_t t);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = t.write;
    bus.req_byte  = t.byte_acc;
    bus.req_addr  = t.addr;
    bus.req_wdata = t.wdata;
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    chk("accept.req_ready", bus.req_ready, 1);
    chk("accept.resp_valid", bus.resp_valid, 0);
    chk("accept.stall", bus.stall, !t.exp_mis);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_byte  = 1'($urandom);
    bus.req_write = 1'($urandom);
    if (!t.exp_mis) begin
      n = (t.ack_cyc >= 1 && t.ack_cyc <= MW) ? t.ack_cyc : MW;
      for (int c = 1; c <= n; c++) begin
        bus.mem_ack   = (c == t.ack_cyc);
        bus.mem_rdata = (c == t.ack_cyc) ? t.rdata : $urandom;
        @(negedge clk);
        chk("access.mem_en", bus.mem_en, 1);
        chk("access.mem_addr", bus.mem_addr, t.exp_maddr);
        chk("access.mem_be", bus.mem_be, t.exp_be);
        chk("access.mem_we", bus.mem_we, t.write);
        if (t.write) chk("access.mem_wdata", bus.mem_wdata, t.exp_wdata);
        chk("access.stall", bus.stall, 1);
        chk("access.req_ready", bus.req_ready, 0);
        chk("access.resp_valid", bus.resp_valid, 0);
        @(posedge clk); #1;
      end
    end
    bus.mem_ack   = t.late_ack;
    bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("resp.resp_valid", bus.resp_valid, 1);
    chk("resp.misaligned_err", bus.misaligned_err, t.exp_mis);
    chk("resp.timeout_err", bus.timeout_err, t.exp_to);
    chk("resp.mem_en", bus.mem_en, 0);
    chk("resp.stall", bus.stall, 0);
    chk("resp.load_word", bus.load_word, t.exp_lw);
    chk("resp.load_byte", bus.load_byte, t.exp_lb);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    ml_word = t.exp_lw;
    ml_byte = t.exp_lb;
  endtask

  txn_t tbl[10];
  txn_t t;

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    tbl[0] = mk(0, 0, 32'h100, 0, 32'hDEADBEEF, 3, 0, 4'hF, 32'h100, 0, 0, 0,
                32'hDEADBEEF, 8'hEF);
    tbl[1] = mk(0, 1, 32'h203, 0, 32'h80FF7F01, 1, 0, 4'b1000, 32'h200, 0, 0, 0,
                32'h80FF7F01, 8'h80);
    tbl[2] = mk(0, 1, 32'h201, 0, 32'h80FF7F01, 2, 0, 4'b0010, 32'h200, 0, 0, 0,
                32'h80FF7F01, 8'h7F);
    tbl[3] = mk(1, 1, 32'h302, 32'h12345678, 32'h0, 1, 0, 4'b0100, 32'h300, 32'h78787878,
                0, 0, 32'h80FF7F01, 8'h7F);
    tbl[4] = mk(0, 0, 32'h106, 0, 32'h55555555, 1, 0, 4'hF, 32'h104, 0, 1, 0,
                32'h80FF7F01, 8'h7F);
    tbl[5] = mk(0, 0, 32'h400, 0, 32'h11111111, 0, 1, 4'hF, 32'h400, 0, 0, 1,
                32'h80FF7F01, 8'h7F);
    tbl[6] = mk(0, 0, 32'h404, 0, 32'hCAFEF00D, MW, 0, 4'hF, 32'h404, 0, 0, 0,
                32'hCAFEF00D, 8'h0D);
    tbl[7] = mk(1, 0, 32'h500, 32'hA5A55A5A, 32'h0, 2, 0, 4'hF, 32'h500, 32'hA5A55A5A,
                0, 0, 32'hCAFEF00D, 8'h0D);
    tbl[8] = mk(1, 0, 32'h503, 32'h01020304, 32'h0, 1, 1, 4'hF, 32'h500, 0, 1, 0,
                32'hCAFEF00D, 8'h0D);
    tbl[9] = mk(0, 1, 32'h7F0, 0, 32'h12345678, 1, 0, 4'b0001, 32'h7F0, 0, 0, 0,
                32'h12345678, 8'h78);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ctx = "reset";
    check_reset_state();
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      ctx = $sformatf("tbl[%0d]", i);
      run_txn(tbl[i]);
    end

    // A stray ack while idle must be ignored.
    ctx = "idle_ack";
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("resp_valid", bus.resp_valid, 0);
    chk("mem_en", bus.mem_en, 0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("resp_valid", bus.resp_valid, 0);
    chk("load_word", bus.load_word, ml_word);
    chk("req_ready", bus.req_ready, 1);
    @(posedge clk); #1;

    // Reset in the middle of an access aborts it with no response.
    ctx = "mid_rst";
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_addr = 32'h600;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mem_en_before", bus.mem_en, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    @(negedge clk);
    chk("post.resp_valid", bus.resp_valid, 0);
    chk("post.mem_en", bus.mem_en, 0);
    ml_word = '0;
    ml_byte = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      ctx = $sformatf("rand[%0d]", i);
      t.write    = 1'($urandom);
      t.byte_acc = 1'($urandom);
      t.addr     = $urandom;
      t.wdata    = $urandom;
      t.rdata    = $urandom;
      t.ack_cyc  = int'($urandom_range(0, MW + 1));
      t.late_ack = 1'($urandom);
      t = predict(t);
      run_txn(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
